// File: rtl/adc_scan_ctrl_if.sv
// SPI_mstr16 transaction bus between the scan controller and the SPI master.
// The controller drives the strobe and command; the master returns done and the read word.
interface adc_scan_ctrl_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;

    modport master (output wrt, cmd, input done, rd_data);
    modport slave  (input wrt, cmd, output done, rd_data);
endinterface

// File: rtl/adc_scan_ctrl.sv
// Scans the ADC channels enabled in a mask, lowest first, issuing two SPI reads per channel
// because the ADC returns the previously selected channel's conversion.
module adc_scan_ctrl #(
    parameter int unsigned GAP_CYC = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   strt_scan_i,
    input  logic [7:0]             chnl_mask_i,
    adc_scan_ctrl_if.master        spi,
    output logic                   res_vld_o,
    output logic [2:0]             res_chnl_o,
    output logic [11:0]            res_data_o,
    output logic                   busy_o,
    output logic                   scan_cmplt_o
);

    typedef enum logic [2:0] {IDLE, SEL, WAIT_SEL, GAP, RD, WAIT_RD, NEXT} state_t;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

    state_t      state_q, state_d;
    logic [7:0]  mask_q, mask_d;
    logic [2:0]  chnl_q, chnl_d;
    logic [3:0]  gap_q, gap_d;
    logic        rd_phase_q, rd_phase_d;
    logic        wrt_q, wrt_d;
    logic [15:0] cmd_q, cmd_d;
    logic        res_vld_q, res_vld_d;
    logic [2:0]  res_chnl_q, res_chnl_d;
    logic [11:0] res_data_q, res_data_d;
    logic        busy_q, busy_d;
    logic        cmplt_q, cmplt_d;
    logic [2:0]  low_idx;

    // Descending walk so the lowest set bit is the last one written.
    always_comb begin
        low_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (mask_q[i]) low_idx = 3'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        chnl_d     = chnl_q;
        gap_d      = gap_q;
        rd_phase_d = rd_phase_q;
        wrt_d      = 1'b0;
        cmd_d      = cmd_q;
        res_vld_d  = 1'b0;
        res_chnl_d = res_chnl_q;
        res_data_d = res_data_q;
        busy_d     = busy_q;
        cmplt_d    = 1'b0;
        case (state_q)
            IDLE: begin
                // A request in the completion cycle belongs to the finished scan.
                if (strt_scan_i && !cmplt_q) begin
                    mask_d  = chnl_mask_i;
                    busy_d  = 1'b1;
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (mask_q == 8'h00) begin
                    cmplt_d = 1'b1;
                    busy_d  = 1'b0;
                    cmd_d   = 16'h0000;
                    state_d = IDLE;
                end else begin
                    chnl_d          = low_idx;
                    mask_d[low_idx] = 1'b0;
                    cmd_d           = {2'b00, low_idx, 11'h000};
                    wrt_d           = 1'b1;
                    rd_phase_d      = 1'b0;
                    state_d         = SEL;
                end
            end
            SEL: state_d = WAIT_SEL;
            WAIT_SEL: begin
                if (spi.done) begin
                    gap_d   = 4'd0;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    gap_d = 4'd0;
                    if (rd_phase_q) begin
                        state_d = NEXT;
                    end else begin
                        wrt_d      = 1'b1;
                        rd_phase_d = 1'b1;
                        state_d    = RD;
                    end
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            RD: state_d = WAIT_RD;
            WAIT_RD: begin
                if (spi.done) begin
                    res_vld_d  = 1'b1;
                    res_chnl_d = chnl_q;
                    res_data_d = spi.rd_data[11:0];
                    gap_d      = 4'd0;
                    state_d    = GAP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            mask_q     <= 8'h00;
            chnl_q     <= 3'd0;
            gap_q      <= 4'd0;
            rd_phase_q <= 1'b0;
            wrt_q      <= 1'b0;
            cmd_q      <= 16'h0000;
            res_vld_q  <= 1'b0;
            res_chnl_q <= 3'd0;
            res_data_q <= 12'h000;
            busy_q     <= 1'b0;
            cmplt_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            chnl_q     <= chnl_d;
            gap_q      <= gap_d;
            rd_phase_q <= rd_phase_d;
            wrt_q      <= wrt_d;
            cmd_q      <= cmd_d;
            res_vld_q  <= res_vld_d;
            res_chnl_q <= res_chnl_d;
            res_data_q <= res_data_d;
            busy_q     <= busy_d;
            cmplt_q    <= cmplt_d;
        end
    end

    assign spi.wrt      = wrt_q;
    assign spi.cmd      = cmd_q;
    assign res_vld_o    = res_vld_q;
    assign res_chnl_o   = res_chnl_q;
    assign res_data_o   = res_data_q;
    assign busy_o       = busy_q;
    assign scan_cmplt_o = cmplt_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Bench for adc_scan_ctrl: SPI/ADC model returning the previous channel's sample,
// scoreboard of expected commands and results filled when each scan is requested.
module tb_adc_scan_ctrl;
    localparam int G   = 3;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        strt_scan = 1'b0;
    logic [7:0]  chnl_mask = 8'h00;
    logic        res_vld;
    logic [2:0]  res_chnl;
    logic [11:0] res_data;
    logic        busy;
    logic        scan_cmplt;

    adc_scan_ctrl_if spi();

    adc_scan_ctrl #(.GAP_CYC(G)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .strt_scan_i  (strt_scan),
        .chnl_mask_i  (chnl_mask),
        .spi          (spi.master),
        .res_vld_o    (res_vld),
        .res_chnl_o   (res_chnl),
        .res_data_o   (res_data),
        .busy_o       (busy),
        .scan_cmplt_o (scan_cmplt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wrt_cnt = 0;
    int vld_cnt = 0;
    int cmplt_cnt = 0;

    logic [15:0] exp_cmd[$];
    logic [14:0] exp_res[$];
    logic [11:0] adc_val[8];

    // SPI/ADC model
    logic        model_done = 1'b0;
    logic        spur_done = 1'b0;
    logic [15:0] model_data = 16'h0000;
    bit          gap_spur = 1'b0;
    bit          echo = 1'b0;
    bit          pend = 1'b0;
    int          cd = 0;
    logic [2:0]  prev_ch = 3'd0;
    logic [2:0]  cur_ch = 3'd0;

    assign spi.done    = model_done | spur_done;
    assign spi.rd_data = model_data;

    always @(posedge clk) cyc++;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_done = 1'b0;
            pend = 1'b0;
            echo = 1'b0;
            cd = 0;
        end else begin
            model_done = 1'b0;
            if (echo) begin
                model_done = 1'b1;
                model_data = 16'hFFFF;
                echo = 1'b0;
            end else if (pend) begin
                cd--;
                if (cd == 0) begin
                    model_done = 1'b1;
                    model_data = {4'hA, adc_val[prev_ch]};
                    prev_ch = cur_ch;
                    pend = 1'b0;
                    echo = gap_spur;
                end
            end
            if (spi.wrt) begin
                pend = 1'b1;
                cd = LAT;
                cur_ch = spi.cmd[13:11];
            end
        end
    end

    // Monitor: scoreboard pop/compare and strobe spacing
    int  last_wrt = 0;
    bit  have_last = 1'b0;
    logic [15:0] ec;
    logic [14:0] er;

    always @(negedge clk) begin
        if (rst_n) begin
            if (spi.wrt) begin
                wrt_cnt++;
                checks++;
                if (exp_cmd.size() == 0) begin
                    failures++;
                    $display("FAIL wrt_cmd: unexpected wrt cmd=%h, none required", spi.cmd);
                end else begin
                    ec = exp_cmd.pop_front();
                    if (spi.cmd !== ec) begin
                        failures++;
                        $display("FAIL wrt_cmd: got %h, required %h", spi.cmd, ec);
                    end
                end
                if (have_last) begin
                    checks++;
                    if (cyc - last_wrt < G + 2) begin
                        failures++;
                        $display("FAIL wrt_spacing: got %0d cycles, required >= %0d", cyc - last_wrt, G + 2);
                    end
                end
                last_wrt = cyc;
                have_last = 1'b1;
            end
            if (res_vld) begin
                vld_cnt++;
                checks++;
                if (exp_res.size() == 0) begin
                    failures++;
                    $display("FAIL res: unexpected res_vld chnl=%0d data=%h", res_chnl, res_data);
                end else begin
                    er = exp_res.pop_front();
                    if ({res_chnl, res_data} !== er) begin
                        failures++;
                        $display("FAIL res: got chnl=%0d data=%h, required chnl=%0d data=%h",
                                 res_chnl, res_data, er[14:12], er[11:0]);
                    end
                end
            end
            if (scan_cmplt) cmplt_cnt++;
        end
    end

    task automatic start_scan(input logic [7:0] m);
        for (int i = 0; i < 8; i++) begin
            if (m[i]) begin
                exp_cmd.push_back({2'b00, 3'(i), 11'h000});
                exp_cmd.push_back({2'b00, 3'(i), 11'h000});
                exp_res.push_back({3'(i), adc_val[i]});
            end
        end
        @(negedge clk);
        strt_scan = 1'b1;
        chnl_mask = m;
        @(negedge clk);
        strt_scan = 1'b0;
        chnl_mask = 8'h00;
    endtask

    task automatic wait_cmplt(input int base, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cmplt_cnt > base) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        checks += 7;
        if (spi.wrt !== 1'b0) begin failures++; $display("FAIL rst_wrt: got %b, required 0", spi.wrt); end
        if (spi.cmd !== 16'h0000) begin failures++; $display("FAIL rst_cmd: got %h, required 0000", spi.cmd); end
        if (res_vld !== 1'b0) begin failures++; $display("FAIL rst_res_vld: got %b, required 0", res_vld); end
        if (res_chnl !== 3'd0) begin failures++; $display("FAIL rst_res_chnl: got %0d, required 0", res_chnl); end
        if (res_data !== 12'h000) begin failures++; $display("FAIL rst_res_data: got %h, required 000", res_data); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (scan_cmplt !== 1'b0) begin failures++; $display("FAIL rst_cmplt: got %b, required 0", scan_cmplt); end
    endtask

    task automatic test_single();
        int bw = wrt_cnt, bv = vld_cnt, bc = cmplt_cnt;
        bit ok;
        adc_val[0] = 12'hC00;
        start_scan(8'h01);
        wait_cmplt(bc, 300, ok);
        checks += 4;
        if (!ok) begin failures++; $display("FAIL single_cmplt: timeout, required scan_cmplt"); end
        if (wrt_cnt - bw !== 2) begin failures++; $display("FAIL single_wrt: got %0d, required 2", wrt_cnt - bw); end
        if (vld_cnt - bv !== 1) begin failures++; $display("FAIL single_vld: got %0d, required 1", vld_cnt - bv); end
        if (busy !== 1'b0) begin failures++; $display("FAIL single_busy: got %b, required 0", busy); end
    endtask

    task automatic test_multi();
        int bw = wrt_cnt, bv = vld_cnt, bc = cmplt_cnt;
        bit ok;
        for (int i = 0; i < 8; i++) adc_val[i] = 12'(12'h111 * (i + 1));
        start_scan(8'hA5);
        wait_cmplt(bc, 600, ok);
        checks += 4;
        if (!ok) begin failures++; $display("FAIL multi_cmplt: timeout, required scan_cmplt"); end
        if (wrt_cnt - bw !== 8) begin failures++; $display("FAIL multi_wrt: got %0d, required 8", wrt_cnt - bw); end
        if (vld_cnt - bv !== 4) begin failures++; $display("FAIL multi_vld: got %0d, required 4", vld_cnt - bv); end
        if (exp_res.size() !== 0) begin failures++; $display("FAIL multi_pending: got %0d left, required 0", exp_res.size()); end
    endtask

    task automatic test_empty();
        int bw = wrt_cnt;
        @(negedge clk);
        strt_scan = 1'b1;
        chnl_mask = 8'h00;
        @(negedge clk);
        strt_scan = 1'b0;
        checks += 2;
        if (busy !== 1'b1) begin failures++; $display("FAIL empty_busy1: got %b, required 1", busy); end
        if (scan_cmplt !== 1'b0) begin failures++; $display("FAIL empty_cmplt1: got %b, required 0", scan_cmplt); end
        @(negedge clk);
        checks += 2;
        if (scan_cmplt !== 1'b1) begin failures++; $display("FAIL empty_cmplt2: got %b, required 1", scan_cmplt); end
        if (busy !== 1'b0) begin failures++; $display("FAIL empty_busy2: got %b, required 0", busy); end
        repeat (4) @(negedge clk);
        checks++;
        if (wrt_cnt - bw !== 0) begin failures++; $display("FAIL empty_wrt: got %0d, required 0", wrt_cnt - bw); end
    endtask

    task automatic test_back_to_back();
        int bv = vld_cnt, bc = cmplt_cnt;
        bit seen = 1'b0;
        for (int i = 0; i < 8; i++) adc_val[i] = 12'(12'h0F0 + 12'h203 * i);
        start_scan(8'hFF);
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (scan_cmplt) begin
                strt_scan = 1'b1;
                chnl_mask = 8'h01;
                @(negedge clk);
                strt_scan = 1'b0;
                seen = 1'b1;
                break;
            end
            strt_scan = (k % 4 == 0);
            chnl_mask = 8'h03;
        end
        strt_scan = 1'b0;
        chnl_mask = 8'h00;
        repeat (6) @(negedge clk);
        checks += 4;
        if (!seen) begin failures++; $display("FAIL b2b_cmplt: timeout, required scan_cmplt"); end
        if (vld_cnt - bv !== 8) begin failures++; $display("FAIL b2b_vld: got %0d, required 8", vld_cnt - bv); end
        if (cmplt_cnt - bc !== 1) begin failures++; $display("FAIL b2b_cmplt_cnt: got %0d, required 1", cmplt_cnt - bc); end
        if (busy !== 1'b0) begin failures++; $display("FAIL b2b_busy: got %b, required 0", busy); end
    endtask

    task automatic test_reset_mid();
        int n = 0, bv, bc;
        bit ok = 1'b0, hit = 1'b0;
        adc_val[2] = 12'h2B7;
        adc_val[3] = 12'h3C9;
        start_scan(8'h0C);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (spi.wrt && spi.cmd == 16'h1800) n++;
            if (n == 2) begin hit = 1'b1; break; end
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        exp_cmd.delete();
        exp_res.delete();
        have_last = 1'b0;
        checks += 8;
        if (!hit) begin failures++; $display("FAIL rmid_reach: timeout, required RD of chnl 3"); end
        if (spi.wrt !== 1'b0) begin failures++; $display("FAIL rmid_wrt: got %b, required 0", spi.wrt); end
        if (spi.cmd !== 16'h0000) begin failures++; $display("FAIL rmid_cmd: got %h, required 0000", spi.cmd); end
        if (res_vld !== 1'b0) begin failures++; $display("FAIL rmid_res_vld: got %b, required 0", res_vld); end
        if (res_chnl !== 3'd0) begin failures++; $display("FAIL rmid_res_chnl: got %0d, required 0", res_chnl); end
        if (res_data !== 12'h000) begin failures++; $display("FAIL rmid_res_data: got %h, required 000", res_data); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b, required 0", busy); end
        if (scan_cmplt !== 1'b0) begin failures++; $display("FAIL rmid_cmplt: got %b, required 0", scan_cmplt); end
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        bv = vld_cnt;
        bc = cmplt_cnt;
        repeat (10) @(negedge clk);
        checks += 2;
        if (vld_cnt - bv !== 0) begin failures++; $display("FAIL rmid_no_vld: got %0d, required 0", vld_cnt - bv); end
        if (cmplt_cnt - bc !== 0) begin failures++; $display("FAIL rmid_no_cmplt: got %0d, required 0", cmplt_cnt - bc); end
        start_scan(8'h08);
        wait_cmplt(bc, 300, ok);
        checks += 2;
        if (!ok) begin failures++; $display("FAIL rmid_rescan: timeout, required scan_cmplt"); end
        if (vld_cnt - bv !== 1) begin failures++; $display("FAIL rmid_rescan_vld: got %0d, required 1", vld_cnt - bv); end
    endtask

    task automatic test_spurious();
        int bw = wrt_cnt, bv = vld_cnt, bc = cmplt_cnt;
        bit ok;
        @(negedge clk);
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        repeat (4) @(negedge clk);
        checks += 3;
        if (busy !== 1'b0) begin failures++; $display("FAIL spur_idle_busy: got %b, required 0", busy); end
        if (wrt_cnt - bw !== 0) begin failures++; $display("FAIL spur_idle_wrt: got %0d, required 0", wrt_cnt - bw); end
        if (vld_cnt - bv !== 0) begin failures++; $display("FAIL spur_idle_vld: got %0d, required 0", vld_cnt - bv); end
        adc_val[6] = 12'h5A5;
        gap_spur = 1'b1;
        start_scan(8'h40);
        wait_cmplt(bc, 300, ok);
        gap_spur = 1'b0;
        checks += 3;
        if (!ok) begin failures++; $display("FAIL spur_gap_cmplt: timeout, required scan_cmplt"); end
        if (wrt_cnt - bw !== 2) begin failures++; $display("FAIL spur_gap_wrt: got %0d, required 2", wrt_cnt - bw); end
        if (vld_cnt - bv !== 1) begin failures++; $display("FAIL spur_gap_vld: got %0d, required 1", vld_cnt - bv); end
    endtask

    initial begin
        for (int i = 0; i < 8; i++) adc_val[i] = 12'h000;
        test_reset();
        test_single();
        test_multi();
        test_empty();
        test_back_to_back();
        test_reset_mid();
        test_spurious();
        repeat (5) @(negedge clk);
        checks++;
        if (exp_cmd.size() !== 0) begin
            failures++;
            $display("FAIL final_cmds: got %0d outstanding, required 0", exp_cmd.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
